req_latch_8: RTL and testbench
==============================

REQ_LATCH_8 -- requirements
Module: req_latch_8

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-002 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-003 req  input  8  raw request lines, already synchronous to clk; bit i = request source i.
REQ-004 mask_we  input  1  mask write strobe.
REQ-005 mask_in  input  8  new mask value, loaded when mask_we=1.
REQ-006 ack  input  1  acknowledge strobe; clears the pending bit selected by ack_idx.
REQ-007 ack_idx  input  3  index (0..7) of the request being acknowledged.
REQ-008 ovf_clr  input  1  clears all sticky overflow flags.
REQ-009 D  output  8  masked pending vector (pend & mask) driving the downstream 8-to-3 priority encoder.
REQ-010 any  output  1  OR of all D bits.
REQ-011 pend  output  8  raw pending register, unmasked.
REQ-012 ovf  output  8  sticky per-line overflow flags.
REQ-013 ack_err  output  1  one-cycle pulse: ack issued for a line whose pend bit was 0.

Function
REQ-014 Block holds registers pend[7:0], mask[7:0], ovf[7:0], req_q[7:0] and ack_err; D and any are combinational from pend and mask only, with no input-to-output combinational path.
REQ-015 Per cycle, event[i] is derived from req (edge- or level-qualified per REQ-029/030); clr[i] = ack & (ack_idx == i).
REQ-016 Next pend[i] = event[i] | (pend[i] & ~clr[i]); event and clear on the same bit in the same cycle leave pend[i]=1 (set wins).
REQ-017 Latency: event sampled at edge k gives pend[i]=1 and, if mask[i]=1, D[i]=1 and any=1 immediately after edge k; ack at edge k gives D[i]=0 after edge k unless a new event arrives.
REQ-018 ack acts on exactly one line per cycle; other pend bits are unaffected.
REQ-019 ack_err = ack & ~pend[ack_idx], registered, high for exactly the cycle after the offending edge; pend is unchanged by an erroneous ack.
REQ-020 Next ovf[i] = (event[i] & pend[i] & ~clr[i]) | (ovf[i] & ~ovf_clr); a new overflow in the same cycle as ovf_clr leaves that bit set.
REQ-021 mask_we=1 loads mask <= mask_in at the edge; the effect on D is visible after that edge.
REQ-022 Masked lines still latch pending and overflow; unmasking a pending line raises its D bit with no new event.
REQ-023 mask_we, ack and ovf_clr may all be asserted in one cycle; each applies independently per REQ-016, REQ-020 and REQ-021.
REQ-024 req_q <= req every cycle in both configurations.

Reset
REQ-025 When rst_n=0 at a rising edge: pend=8'h00, ovf=8'h00, ack_err=0, req_q=8'h00, mask=8'hFF; hence D=8'h00 and any=0.
REQ-026 Reset takes priority over every other input, including during an in-flight ack or mask write; all state is lost.
REQ-027 The first edge with rst_n=1 is a normal cycle; in edge mode, a req line held high across reset produces one event on that edge, because req_q=0.

Configuration
REQ-028 Macro REQ_LATCH_EDGE_EN selects the event qualification.
REQ-029 REQ_LATCH_EDGE_EN defined: event = req & ~req_q, so only rising edges set pend; a line held high sets pend once.
REQ-030 REQ_LATCH_EDGE_EN undefined: event = req (level), so a line held high re-sets pend every cycle; ack of a still-high line shows pend=1 again after the edge, and ovf sets on the second consecutive cycle of an un-acked high level. req_q is still registered, but unused.

Verification
REQ-031 Reset, then req=8'h05 for one cycle -> pend=8'h05, D=8'h05, any=1; ack=1 with ack_idx=0 -> pend=8'h04, ack_err=0.
REQ-032 pend=8'h00, ack=1 with ack_idx=3 -> ack_err=1 for one cycle, pend stays 8'h00.
REQ-033 Edge mode: req[6] pulses twice with no ack between -> pend[6]=1, ovf=8'h40; then ovf_clr=1 -> ovf=8'h00.
REQ-034 mask_we=1 with mask_in=8'h0F, then req=8'hF0 pulse -> pend=8'hF0, D=8'h00, any=0; mask_we=1 with mask_in=8'hFF -> D=8'hF0.
REQ-035 Same cycle: req[2] rising edge and ack with ack_idx=2 while pend[2]=1 -> pend[2]=1, ovf[2]=0.
REQ-036 pend=8'hFF, ovf=8'h11, mask=8'h00, rst_n=0 for one edge -> pend=8'h00, ovf=8'h00, mask=8'hFF, D=8'h00; repeat in level mode with req[1] held high -> pend=8'h02 on the first edge after reset release.

Source files
------------

// File: rtl/req_latch_8.sv
// req_latch_8: eight-line request latch with per-line mask, single-line
// acknowledge, sticky overflow flags and an ack-error pulse. D/any feed a
// downstream 8-to-3 priority encoder.
// Optional feature: define REQ_LATCH_EDGE_EN for rising-edge request
// qualification; leave it undefined for level qualification.
module req_latch_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       mask_we,
    input  logic [7:0] mask_in,
    input  logic       ack,
    input  logic [2:0] ack_idx,
    input  logic       ovf_clr,
    output logic [7:0] D,
    output logic       any,
    output logic [7:0] pend,
    output logic [7:0] ovf,
    output logic       ack_err
);

    localparam int unsigned N = 8;

    logic [N-1:0] mask;
    logic [N-1:0] req_q;
    logic [N-1:0] evt_c;
    logic [N-1:0] clr_c;
    logic [N-1:0] pend_nxt_c;
    logic [N-1:0] ovf_nxt_c;

    // Event qualification, one-hot clear and next pending/overflow state
    always_comb begin
        evt_c      = '0;
        clr_c      = '0;
        pend_nxt_c = pend;
        ovf_nxt_c  = ovf;
`ifdef REQ_LATCH_EDGE_EN
        evt_c = req & ~req_q;
`else
        // Level mode: the req_q term is absorbed by req, leaving event = req
        evt_c = req | (req & ~req_q);
`endif
        if (ack) begin
            clr_c = N'(1) << ack_idx;
        end
        // Set wins over clear on the same line
        pend_nxt_c = evt_c | (pend & ~clr_c);
        // A new overflow beats ovf_clr on the same line
        ovf_nxt_c  = (evt_c & pend & ~clr_c) | (ovf & {N{~ovf_clr}});
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend    <= '0;
            ovf     <= '0;
            mask    <= '1;
            req_q   <= '0;
            ack_err <= 1'b0;
        end else begin
            pend    <= pend_nxt_c;
            ovf     <= ovf_nxt_c;
            req_q   <= req;
            ack_err <= ack & ~pend[ack_idx];
            if (mask_we) begin
                mask <= mask_in;
            end
        end
    end

    // Masked pending vector and summary bit for the priority encoder
    assign D   = pend & mask;
    assign any = |D;

endmodule

// File: tb/tb_req_latch_8.sv
// tb_req_latch_8: directed scenarios followed by random traffic, each cycle
// compared against a per-line behavioural model of the request latch.
module tb_req_latch_8;

`ifdef REQ_LATCH_EDGE_EN
    localparam bit LEVEL = 1'b0;
`else
    localparam bit LEVEL = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       ack;
    logic [2:0] ack_idx;
    logic       ovf_clr;
    logic [7:0] D;
    logic       any;
    logic [7:0] pend;
    logic [7:0] ovf;
    logic       ack_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: one flag per line
    bit m_pend [8];
    bit m_ovf  [8];
    bit m_mask [8];
    bit m_prev [8];
    bit m_err;

    req_latch_8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask_we (mask_we),
        .mask_in (mask_in),
        .ack     (ack),
        .ack_idx (ack_idx),
        .ovf_clr (ovf_clr),
        .D       (D),
        .any     (any),
        .pend    (pend),
        .ovf     (ovf),
        .ack_err (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pack(input bit a [8]);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = a[i];
        return v;
    endfunction

    // Compare every DUT output with the model
    task automatic check_all(input string tag);
        logic [7:0] exp_d;
        for (int i = 0; i < 8; i++) exp_d[i] = m_pend[i] && m_mask[i];
        check({tag, "_pend"}, pend, pack(m_pend));
        check({tag, "_ovf"},  ovf,  pack(m_ovf));
        check({tag, "_D"},    D,    exp_d);
        check({tag, "_any"},  8'(any), 8'(exp_d != 8'h00));
        check({tag, "_err"},  8'(ack_err), 8'(m_err));
    endtask

    // Apply one cycle of inputs, advance model and DUT, then compare
    task automatic step(input string tag, input logic rn, input logic [7:0] r,
                        input logic mw, input logic [7:0] mi, input logic a,
                        input logic [2:0] ai, input logic oc);
        bit n_pend [8];
        bit n_ovf  [8];
        bit n_err;
        rst_n = rn; req = r; mask_we = mw; mask_in = mi;
        ack = a; ack_idx = ai; ovf_clr = oc;
        n_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit ev, hit;
            ev  = LEVEL ? r[i] : (r[i] && !m_prev[i]);
            hit = a && (int'(ai) == i);
            n_pend[i] = ev || (m_pend[i] && !hit);
            n_ovf[i]  = (ev && m_pend[i] && !hit) || (m_ovf[i] && !oc);
        end
        if (a && !m_pend[ai]) n_err = 1'b1;
        @(posedge clk);
        #1;
        if (!rn) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0; m_ovf[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
            end
            m_err = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = n_pend[i];
                m_ovf[i]  = n_ovf[i];
                m_prev[i] = r[i];
                if (mw) m_mask[i] = mi[i];
            end
            m_err = n_err;
        end
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask_we = 1'b0; mask_in = '0;
        ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
        end
        m_err = 0;

        // Reset state
        step("rst", 0, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        step("rst", 0, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        check("rst_pend_k", pend, 8'h00);
        check("rst_D_k", D, 8'h00);

        // Basic latch and acknowledge
        step("set05", 1, 8'h05, 0, 8'h00, 0, 3'd0, 0);
        check("set05_pend_k", pend, 8'h05);
        check("set05_D_k", D, 8'h05);
        check("set05_any_k", 8'(any), 8'h01);
        step("ack0", 1, 8'h00, 0, 8'h00, 1, 3'd0, 0);
        check("ack0_pend_k", pend, 8'h04);
        check("ack0_err_k", 8'(ack_err), 8'h00);
        step("ack2", 1, 8'h00, 0, 8'h00, 1, 3'd2, 0);

        // Erroneous ack on an empty line
        step("bad3", 1, 8'h00, 0, 8'h00, 1, 3'd3, 0);
        check("bad3_err_k", 8'(ack_err), 8'h01);
        check("bad3_pend_k", pend, 8'h00);
        step("bad3_off", 1, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        check("bad3_off_err_k", 8'(ack_err), 8'h00);

        // Overflow on line 6, then clear
        step("ov_a", 1, 8'h40, 0, 8'h00, 0, 3'd0, 0);
        step("ov_b", 1, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        step("ov_c", 1, 8'h40, 0, 8'h00, 0, 3'd0, 0);
        check("ov_c_ovf_k", ovf, 8'h40);
        step("ov_d", 1, 8'h00, 0, 8'h00, 0, 3'd0, 1);
        check("ov_d_ovf_k", ovf, 8'h00);

        // Masked lines still latch; unmask exposes them
        step("mk_a", 1, 8'h00, 1, 8'h0F, 0, 3'd0, 0);
        step("mk_b", 1, 8'hF0, 0, 8'h00, 0, 3'd0, 0);
        check("mk_b_pend_k", pend, 8'hF0);
        check("mk_b_D_k", D, 8'h00);
        step("mk_c", 1, 8'h00, 1, 8'hFF, 0, 3'd0, 0);
        check("mk_c_D_k", D, 8'hF0);

        // Set beats clear on line 2, no overflow
        step("sc_a", 1, 8'h04, 0, 8'h00, 0, 3'd0, 0);
        step("sc_b", 1, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        step("sc_c", 1, 8'h04, 0, 8'h00, 1, 3'd2, 0);
        check("sc_c_pend2_k", 8'(pend[2]), 8'h01);
        check("sc_c_ovf2_k", 8'(ovf[2]), 8'h00);
        step("sc_d", 1, 8'h00, 0, 8'h00, 0, 3'd0, 0);

        // Reset wipes everything mid-operation
        step("rr_a", 1, 8'hFF, 0, 8'h00, 0, 3'd0, 0);
        step("rr_b", 1, 8'h00, 0, 8'h00, 0, 3'd0, 1);
        step("rr_c", 1, 8'h11, 1, 8'h00, 0, 3'd0, 1);
        check("rr_c_ovf_k", ovf, 8'h11);
        step("rr_d", 0, 8'h02, 1, 8'h55, 1, 3'd1, 0);
        check("rr_d_pend_k", pend, 8'h00);
        check("rr_d_ovf_k", ovf, 8'h00);
        check("rr_d_D_k", D, 8'h00);
        step("rr_e", 1, 8'h02, 0, 8'h00, 0, 3'd0, 0);
        check("rr_e_pend_k", pend, 8'h02);
        check("rr_e_D_k", D, 8'h02);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 logic'($urandom_range(0, 49) != 0),
                 8'($urandom & $urandom),
                 logic'($urandom_range(0, 9) == 0),
                 8'($urandom),
                 logic'($urandom_range(0, 2) == 0),
                 3'($urandom),
                 logic'($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
